// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the shared
// 32-bit logic unit. The arbiter takes the slave side; the environment takes master.
interface logic_op_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  req0;
    logic [1:0]            op0;
    logic [DATA_WIDTH-1:0] a0;
    logic [DATA_WIDTH-1:0] b0;
    logic                  ack0;

    logic                  req1;
    logic [1:0]            op1;
    logic [DATA_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] b1;
    logic                  ack1;

    logic [1:0]            lu_op;
    logic [DATA_WIDTH-1:0] lu_a;
    logic [DATA_WIDTH-1:0] lu_b;
    logic [DATA_WIDTH-1:0] lu_y;

    logic [DATA_WIDTH-1:0] result;
    logic                  result_owner;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  op_count;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, lu_y,
        output ack0, ack1, lu_op, lu_a, lu_b, result, result_owner, busy, op_count
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, lu_y,
        input  ack0, ack1, lu_op, lu_a, lu_b, result, result_owner, busy, op_count
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter that time-shares one combinational logic unit between two
// requesters: grant in IDLE, evaluate in EXEC, acknowledge in DONE.
module logic_op_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    logic_op_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  grant;
    logic                  grant_sel;
    logic                  owner;
    logic                  last_grant;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_owner_q;
    logic [CNT_WIDTH-1:0]  count_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant      = 1'b1;
                    grant_sel  = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the very first tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            result_q       <= '0;
            result_owner_q <= 1'b0;
            count_q        <= '0;
        end else begin
            if (grant) begin
                op_q       <= grant_sel ? bus.op1 : bus.op0;
                a_q        <= grant_sel ? bus.a1  : bus.a0;
                b_q        <= grant_sel ? bus.b1  : bus.b0;
                owner      <= grant_sel;
                last_grant <= grant_sel;
            end
            if (state == EXEC) begin
                result_q       <= bus.lu_y;
                result_owner_q <= owner;
            end
            if (state == DONE) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.lu_op        = op_q;
    assign bus.lu_a         = a_q;
    assign bus.lu_b         = b_q;
    assign bus.result       = result_q;
    assign bus.result_owner = result_owner_q;
    assign bus.op_count     = count_q;
    assign bus.busy         = (state == EXEC) || (state == DONE);
    assign bus.ack0         = (state == DONE) && !owner;
    assign bus.ack1         = (state == DONE) && owner;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: transaction-level reference model plus directed
// literal checks; a narrow op counter keeps the wrap check short.
module tb_logic_op_arbiter;

    localparam int DW = 32;
    localparam int CW = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic_op_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    logic_op_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [DW-1:0] logic_fn(input logic [1:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    // Stand-in for the shared gate-level logic unit.
    assign bus.lu_y = logic_fn(bus.lu_op, bus.lu_a, bus.lu_b);

    int checks = 0;
    int errors = 0;

    // Model: one scheduled operation, granted at edge g_edge, acked in cycle g_edge+1.
    int            cyc;
    bit            have_grant;
    int            g_edge;
    bit            m_owner;
    bit            m_last;
    logic [DW-1:0] m_y;
    logic [1:0]    exp_lu_op;
    logic [DW-1:0] exp_lu_a;
    logic [DW-1:0] exp_lu_b;
    logic [DW-1:0] exp_result;
    bit            exp_owner;
    int            exp_count;

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        have_grant = 1'b0;
        g_edge     = 0;
        m_owner    = 1'b0;
        m_last     = 1'b1;
        m_y        = '0;
        exp_lu_op  = '0;
        exp_lu_a   = '0;
        exp_lu_b   = '0;
        exp_result = '0;
        exp_owner  = 1'b0;
        exp_count  = 0;
    endtask

    task automatic predict();
        bit winner;
        if ((!have_grant || (cyc + 1 >= g_edge + 3)) && (bus.req0 || bus.req1)) begin
            winner     = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            have_grant = 1'b1;
            g_edge     = cyc + 1;
            m_owner    = winner;
            m_last     = winner;
            exp_lu_op  = winner ? bus.op1 : bus.op0;
            exp_lu_a   = winner ? bus.a1  : bus.a0;
            exp_lu_b   = winner ? bus.b1  : bus.b0;
            m_y        = logic_fn(exp_lu_op, exp_lu_a, exp_lu_b);
        end
    endtask

    task automatic checkOutput();
        bit e_busy;
        bit e_done;
        e_busy = have_grant && (cyc == g_edge || cyc == g_edge + 1);
        e_done = have_grant && (cyc == g_edge + 1);
        if (e_done) begin
            exp_result = m_y;
            exp_owner  = m_owner;
        end
        if (have_grant && cyc == g_edge + 2) exp_count = (exp_count + 1) % (1 << CW);
        compare("ack0",         {31'b0, bus.ack0},         {31'b0, e_done && !m_owner});
        compare("ack1",         {31'b0, bus.ack1},         {31'b0, e_done && m_owner});
        compare("busy",         {31'b0, bus.busy},         {31'b0, e_busy});
        compare("result",       bus.result,                exp_result);
        compare("result_owner", {31'b0, bus.result_owner}, {31'b0, exp_owner});
        compare("op_count",     32'(bus.op_count),         exp_count);
        compare("lu_op",        {30'b0, bus.lu_op},        {30'b0, exp_lu_op});
        compare("lu_a",         bus.lu_a,                  exp_lu_a);
        compare("lu_b",         bus.lu_b,                  exp_lu_b);
    endtask

    task automatic step();
        predict();
        @(negedge CLK);
        cyc++;
        checkOutput();
    endtask

    task automatic run_until_ack(input int which, input int bound, output int steps);
        bit seen;
        steps = 0;
        seen  = 1'b0;
        while (!seen && steps < bound) begin
            step();
            steps++;
            if ((which == 0) ? bus.ack0 : bus.ack1) begin
                seen = 1'b1;
                if (which == 0) bus.req0 = 1'b0;
                else            bus.req1 = 1'b0;
            end
        end
        compare("ack_seen", {31'b0, seen}, 32'd1);
    endtask

    // Random requesters: hold req until ack, drop it in the ack cycle, reissue later.
    task automatic applyStimulus();
        if (bus.ack0)          bus.req0 = 1'b0;
        else if (!bus.req0)    bus.req0 = ($urandom_range(0, 3) != 0);
        if (bus.ack1)          bus.req1 = 1'b0;
        else if (!bus.req1)    bus.req1 = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
            bus.op0 = 2'($urandom_range(0, 3));
            bus.a0  = $urandom;
            bus.b0  = $urandom;
        end
        if ($urandom_range(0, 1) == 1) begin
            bus.op1 = 2'($urandom_range(0, 3));
            bus.a1  = $urandom;
            bus.b1  = $urandom;
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int steps;
        int bound;

        RST      = 1'b1;
        bus.req0 = 1'b0; bus.op0 = 2'b00; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = 2'b00; bus.a1 = '0; bus.b1 = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        compare("reset_result",   bus.result,              32'd0);
        compare("reset_busy",     {31'b0, bus.busy},       32'd0);
        compare("reset_op_count", 32'(bus.op_count),       32'd0);
        compare("reset_acks",     {30'b0, bus.ack1, bus.ack0}, 32'd0);
        RST = 1'b0;

        // AND from requester 0, with the exact ack latency.
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 32'd26; bus.b0 = 32'd19;
        run_until_ack(0, 6, steps);
        compare("and_latency", steps, 32'd2);
        compare("and_result",  bus.result, 32'd18);
        compare("and_owner",   {31'b0, bus.result_owner}, 32'd0);
        compare("and_ack1",    {31'b0, bus.ack1}, 32'd0);
        step();
        compare("and_count",   32'(bus.op_count), 32'd1);

        // NOR from requester 1.
        bus.req1 = 1'b1; bus.op1 = 2'b10; bus.a1 = 32'd27; bus.b1 = 32'd13;
        run_until_ack(1, 6, steps);
        compare("nor_result", bus.result, 32'hFFFF_FFE0);
        compare("nor_owner",  {31'b0, bus.result_owner}, 32'd1);
        step();

        // Contention: requester 0 then requester 1.
        bus.req0 = 1'b1; bus.op0 = 2'b11; bus.a0 = 32'hFFFF_FFFF; bus.b0 = 32'h1234_5678;
        bus.req1 = 1'b1; bus.op1 = 2'b01; bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'h0000_FFFF;
        run_until_ack(0, 6, steps);
        compare("tie_first_result", bus.result, 32'd0);
        compare("tie_first_owner",  {31'b0, bus.result_owner}, 32'd0);
        run_until_ack(1, 6, steps);
        compare("tie_second_wait",   steps, 32'd3);
        compare("tie_second_result", bus.result, 32'hFFFF_FFFF);
        compare("tie_second_owner",  {31'b0, bus.result_owner}, 32'd1);
        step();
        compare("tie_count", 32'(bus.op_count), 32'd4);

        // Operand change after the grant must not leak into the operation.
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 32'd26; bus.b0 = 32'd19;
        step();
        bus.a0 = 32'd5;
        compare("late_lu_a_exec", bus.lu_a, 32'd26);
        run_until_ack(0, 6, steps);
        compare("late_lu_a_done", bus.lu_a, 32'd26);
        compare("late_result",    bus.result, 32'd18);
        idle_cycles(2);

        // Asynchronous reset in the middle of EXEC.
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 32'd7; bus.b0 = 32'd3;
        step();
        compare("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
        #2 RST = 1'b1;
        #1;
        compare("async_result", bus.result, 32'd0);
        compare("async_busy",   {31'b0, bus.busy}, 32'd0);
        compare("async_ack0",   {31'b0, bus.ack0}, 32'd0);
        compare("async_lu_a",   bus.lu_a, 32'd0);
        compare("async_count",  32'(bus.op_count), 32'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_until_ack(0, 6, steps);
        compare("post_reset_result", bus.result, 32'd3);
        step();
        compare("post_reset_count", 32'(bus.op_count), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus();
            step();
        end

        // Drive the counter up to its top value, then one more operation wraps it.
        bus.req1 = 1'b0;
        bound = 0;
        while (exp_count != (1 << CW) - 1 && bound < 2000) begin
            if (bus.ack0) bus.req0 = 1'b0;
            else          bus.req0 = 1'b1;
            bus.op0 = 2'($urandom_range(0, 3));
            bus.a0  = $urandom;
            bus.b0  = $urandom;
            step();
            bound++;
        end
        compare("count_at_top", 32'(bus.op_count), (1 << CW) - 1);
        idle_cycles(3);
        bus.req0 = 1'b1; bus.op0 = 2'b01; bus.a0 = 32'h0F0F_0000; bus.b0 = 32'h0000_00F0;
        run_until_ack(0, 6, steps);
        compare("wrap_result", bus.result, 32'h0F0F_00F0);
        step();
        compare("count_wrap", 32'(bus.op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
